// File: rtl/cpu_types_pkg.sv
// Shared types for the CPU memory subsystem: AXI response codes and
// the SRAM responder's FSM states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_RESP,
    S_WR_WAIT,
    S_WR_RESP
  } sram_state_e;

  localparam int LAT_W = 4;

  // Offset is computed modulo 2^32, so addresses below the base wrap high and miss.
  function automatic logic addr_hit(input logic [31:0] off, input int unsigned depth);
    return off < 32'(depth * 4);
  endfunction

endpackage

// File: rtl/sram_byte_mem.sv
// DEPTH x 32 storage with per-byte write enables and a combinational read port.
// Contents are deliberately not reset.
module sram_byte_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wstrb_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder over a byte-writable SRAM with programmable read/write
// response latency; one transaction in flight, writes win over reads.
module axi_lite_sram_slave
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          RD_LAT    = 1,
  parameter int          WR_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axi_araddr_i,
  input  logic        s_axi_arvalid_i,
  output logic        s_axi_arready_o,
  output logic [31:0] s_axi_rdata_o,
  output logic [1:0]  s_axi_rresp_o,
  output logic        s_axi_rvalid_o,
  input  logic        s_axi_rready_i,
  input  logic [31:0] s_axi_awaddr_i,
  input  logic        s_axi_awvalid_i,
  output logic        s_axi_awready_o,
  input  logic [31:0] s_axi_wdata_i,
  input  logic [3:0]  s_axi_wstrb_i,
  input  logic        s_axi_wvalid_i,
  output logic        s_axi_wready_o,
  output logic [1:0]  s_axi_bresp_o,
  output logic        s_axi_bvalid_o,
  input  logic        s_axi_bready_i
);

  localparam int AW = $clog2(DEPTH);

  sram_state_e      state_q;
  logic [LAT_W-1:0] cnt_q;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [3:0]       wstrb_q;
  axi_resp_e        rresp_q, bresp_q;

  logic        idle, aw_w_both, wr_go, rd_go, rd_fire, wr_fire, hit;
  logic [31:0] cur_addr, cur_wdata, off, mem_rdata, rdata_d;
  logic [3:0]  cur_strb;
  axi_resp_e   resp_d;

  assign idle      = (state_q == S_IDLE);
  assign aw_w_both = s_axi_awvalid_i && s_axi_wvalid_i;
  assign wr_go     = idle && aw_w_both;
  assign rd_go     = idle && s_axi_arvalid_i && !aw_w_both;

  assign s_axi_awready_o = wr_go;
  assign s_axi_wready_o  = wr_go;
  assign s_axi_arready_o = idle && !aw_w_both;

  // A latency of 1 fires straight off the handshake, so the live inputs feed the array.
  assign cur_addr  = idle ? (aw_w_both ? s_axi_awaddr_i : s_axi_araddr_i) : addr_q;
  assign cur_wdata = idle ? s_axi_wdata_i : wdata_q;
  assign cur_strb  = idle ? s_axi_wstrb_i : wstrb_q;

  assign off     = cur_addr - BASE_ADDR;
  assign hit     = addr_hit(off, DEPTH);
  assign resp_d  = hit ? RESP_OKAY : RESP_SLVERR;
  assign rdata_d = hit ? mem_rdata : '0;

  assign rd_fire = (rd_go && RD_LAT == 1) || (state_q == S_RD_WAIT && cnt_q == LAT_W'(1));
  assign wr_fire = (wr_go && WR_LAT == 1) || (state_q == S_WR_WAIT && cnt_q == LAT_W'(1));

  sram_byte_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (wr_fire && hit),
    .addr_i  (off[AW+1:2]),
    .wdata_i (cur_wdata),
    .wstrb_i (cur_strb),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      bresp_q <= RESP_OKAY;
    end else begin
      if (rd_fire) begin
        rdata_q <= rdata_d;
        rresp_q <= resp_d;
      end
      if (wr_fire) bresp_q <= resp_d;
      case (state_q)
        S_IDLE: begin
          if (wr_go) begin
            addr_q  <= s_axi_awaddr_i;
            wdata_q <= s_axi_wdata_i;
            wstrb_q <= s_axi_wstrb_i;
            cnt_q   <= LAT_W'(WR_LAT - 1);
            state_q <= (WR_LAT == 1) ? S_WR_RESP : S_WR_WAIT;
          end else if (rd_go) begin
            addr_q  <= s_axi_araddr_i;
            cnt_q   <= LAT_W'(RD_LAT - 1);
            state_q <= (RD_LAT == 1) ? S_RD_RESP : S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          cnt_q <= cnt_q - LAT_W'(1);
          if (rd_fire) state_q <= S_RD_RESP;
        end
        S_RD_RESP: if (s_axi_rready_i) state_q <= S_IDLE;
        S_WR_WAIT: begin
          cnt_q <= cnt_q - LAT_W'(1);
          if (wr_fire) state_q <= S_WR_RESP;
        end
        S_WR_RESP: if (s_axi_bready_i) state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign s_axi_rvalid_o = (state_q == S_RD_RESP);
  assign s_axi_bvalid_o = (state_q == S_WR_RESP);
  assign s_axi_rdata_o  = rdata_q;
  assign s_axi_rresp_o  = rresp_q;
  assign s_axi_bresp_o  = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Bench for axi_lite_sram_slave: vector table plus hand sequences for
// write priority, response stall and mid-transaction reset.
module tb_axi_lite_sram_slave;

  localparam int RL = 2;
  localparam int WL = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  axi_lite_sram_slave #(
    .BASE_ADDR(32'h8000_0000), .DEPTH(1024), .RD_LAT(RL), .WR_LAT(WL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_araddr_i(araddr), .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
    .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp), .s_axi_rvalid_o(rvalid),
    .s_axi_rready_i(rready),
    .s_axi_awaddr_i(awaddr), .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
    .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wvalid_i(wvalid),
    .s_axi_wready_o(wready),
    .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NV = 14;
  vec_t vt[NV];

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er, input bit early);
    int t, n;
    exp_t e, g;
    @(negedge clk);
    if (early) bready = 1'b1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!(awready && wready) && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) begin
      chk("aw_w_accept_timeout", 32'd0, 32'd1);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    t = cyc;
    e.data = '0; e.resp = er; e.lat = WL;
    exp_q.push_back(e);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); #1; n++; end
    g = exp_q.pop_front();
    if (n >= 50) begin
      chk("bvalid_timeout", 32'd0, 32'd1);
      return;
    end
    chk("bresp", 32'(bresp), 32'(g.resp));
    chk("b_latency", 32'(cyc - t), 32'(g.lat));
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bvalid_after_hs", 32'(bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                         input int stall, input bit early);
    int t, n;
    logic [31:0] d0;
    exp_t e, g;
    @(negedge clk);
    if (early) rready = 1'b1;
    araddr = a; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) begin
      chk("ar_accept_timeout", 32'd0, 32'd1);
      arvalid = 1'b0;
      return;
    end
    t = cyc;
    e.data = ed; e.resp = er; e.lat = RL;
    exp_q.push_back(e);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); #1; n++; end
    g = exp_q.pop_front();
    if (n >= 50) begin
      chk("rvalid_timeout", 32'd0, 32'd1);
      return;
    end
    chk("rdata", rdata, g.data);
    chk("rresp", 32'(rresp), 32'(g.resp));
    chk("r_latency", 32'(cyc - t), 32'(g.lat));
    d0 = rdata;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk); #1;
      chk("r_hold_valid", 32'(rvalid), 32'd1);
      chk("r_hold_data", rdata, d0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("rvalid_after_hs", 32'(rvalid), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, t;
    bit seen;

    vt[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
    vt[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
    vt[2]  = '{1'b1, 32'h8000_0010, 32'h0000_00AA, 4'h1, 32'h0,         2'b00};
    vt[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA, 2'b00};
    vt[4]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0,         2'b00};
    vt[5]  = '{1'b0, 32'h8000_1000, 32'h0,         4'h0, 32'h0,         2'b10};
    vt[6]  = '{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0,         2'b10};
    vt[7]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b00};
    vt[8]  = '{1'b1, 32'h8000_0FFC, 32'h1122_3344, 4'hF, 32'h0,         2'b00};
    vt[9]  = '{1'b1, 32'h8000_0FFC, 32'hAABB_CCDD, 4'h6, 32'h0,         2'b00};
    vt[10] = '{1'b0, 32'h8000_0FFE, 32'h0,         4'h0, 32'h11BB_CC44, 2'b00};
    vt[11] = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0,         2'b00};
    vt[12] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA, 2'b00};
    vt[13] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10};

    rst_n = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    #23;
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_bvalid", 32'(bvalid), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_rresp", 32'(rresp), 32'd0);
    chk("reset_bresp", 32'(bresp), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("idle_arready", 32'(arready), 32'd1);
    chk("idle_awready", 32'(awready), 32'd0);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].wr) do_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].exp_resp, 1'b0);
      else          do_read(vt[i].addr, vt[i].exp_data, vt[i].exp_resp, 0, 1'b0);
    end

    // Early readies must not shorten latency or produce extra beats.
    do_write(32'h8000_0040, 32'h0102_0304, 4'hF, 2'b00, 1'b1);
    do_read(32'h8000_0040, 32'h0102_0304, 2'b00, 0, 1'b1);

    // Concurrent AR and AW+W: write wins, read waits for the B handshake.
    @(negedge clk);
    awaddr = 32'h8000_0020; wdata = 32'h5A5A_0001; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h8000_0020; arvalid = 1'b1;
    #1;
    chk("prio_arready", 32'(arready), 32'd0);
    chk("prio_awready", 32'(awready), 32'd1);
    t = cyc;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    seen = 1'b0; n = 0;
    while (!bvalid && n < 50) begin
      if (arready) seen = 1'b1;
      @(negedge clk); #1; n++;
    end
    if (arready) seen = 1'b1;
    chk("prio_b_latency", 32'(cyc - t), 32'(WL));
    chk("prio_ar_blocked", 32'(seen), 32'd0);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("prio_arready_after_b", 32'(arready), 32'd1);
    t = cyc;
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); #1; n++; end
    chk("prio_r_latency", 32'(cyc - t), 32'(RL));
    chk("prio_rdata", rdata, 32'h5A5A_0001);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;

    // Stalled R channel: five cycles with rready low, then one beat only.
    do_read(32'h8000_0010, 32'hDEAD_BEAA, 2'b00, 5, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (rvalid) seen = 1'b1;
    end
    chk("single_r_beat", 32'(seen), 32'd0);

    // Reset while the read is still waiting.
    @(negedge clk);
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (rvalid) seen = 1'b1;
    end
    chk("rst_wait_no_beat", 32'(seen), 32'd0);

    // Reset while a response is being held: outputs drop without a clock edge.
    @(negedge clk);
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); #1; n++; end
    chk("rst_resp_pre_rdata", rdata, 32'hDEAD_BEAA);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_resp_rvalid", 32'(rvalid), 32'd0);
    chk("rst_resp_rdata", rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      if (rvalid) seen = 1'b1;
    end
    chk("rst_resp_no_beat", 32'(seen), 32'd0);

    do_read(32'h8000_0010, 32'hDEAD_BEAA, 2'b00, 0, 1'b0);
    do_read(32'h8000_0000, 32'hCAFE_F00D, 2'b00, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
